mipi_rgb555_packer: RTL and testbench

//  Sits between the MIPI receiver stream output (mipi_st_*, RGB888) and the SDRAM

---
 rtl/mipi_rgb555_packer.sv | 133 +++++++++++++
 tb/tb_mipi_rgb555_packer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mipi_rgb555_packer.sv
// mipi_rgb555_packer: MIPI RGB888 stream -> cropped RGB555 arbiter write stream; optional dither via MIPI_RGB555_DITHER_EN
module mipi_rgb555_packer #(
    parameter int IMG_W   = 640,
    parameter int IMG_H   = 480,
    parameter int CROP_X0 = 0,
    parameter int CROP_Y0 = 0,
    parameter int OUT_W   = 640,
    parameter int OUT_H   = 480
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic [23:0] mipi_st_data,
    input  logic        mipi_st_start,
    input  logic        mipi_st_dv,
    output logic [14:0] arb_mipi_data,
    output logic        arb_mipi_dv,
    output logic        arb_mipi_start,
    output logic [15:0] frame_cnt,
    output logic        frame_err,
    output logic        in_frame
);
    localparam int XW = $clog2(IMG_W > 1 ? IMG_W : 2);
    localparam int YW = $clog2(IMG_H > 1 ? IMG_H : 2);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t      state_q, state_d;
    logic [XW-1:0] x_q, x_d, px;
    logic [YW-1:0] y_q, y_d, py;
    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        s1_v_q, s1_v_d, s1_start_q, s1_start_d;
    logic [23:0] s1_pix_q, s1_pix_d;
    logic        out_dv_q, out_dv_d, out_start_q, out_start_d;
    logic [14:0] out_data_q, out_data_d, rgb;
    logic        accept, last_x, last, pass;
`ifdef MIPI_RGB555_DITHER_EN
    logic        s1_x0_q, s1_x0_d, s1_y0_q, s1_y0_d;
    logic [7:0]  thr;

    function automatic logic [4:0] dith5(input logic [7:0] c, input logic [7:0] t);
        logic [8:0] s;
        s = {1'b0, c} + {1'b0, t};
        return s[8] ? 5'h1f : s[7:3];
    endfunction
`endif

    // Frame tracking: a start beat is always pixel (0,0); otherwise the beat takes the held position
    always_comb begin
        accept  = mipi_st_dv && (mipi_st_start || state_q == ACTIVE);
        px      = mipi_st_start ? '0 : x_q;
        py      = mipi_st_start ? '0 : y_q;
        last_x  = int'(px) == IMG_W - 1;
        last    = last_x && int'(py) == IMG_H - 1;
        pass    = accept && int'(px) >= CROP_X0 && int'(px) < CROP_X0 + OUT_W
                         && int'(py) >= CROP_Y0 && int'(py) < CROP_Y0 + OUT_H;
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        err_d   = mipi_st_dv && mipi_st_start && state_q == ACTIVE;
        if (accept) begin
            state_d = last ? IDLE : ACTIVE;
            cnt_d   = last ? cnt_q + 16'd1 : cnt_q;
            x_d     = last_x ? '0 : px + 1'b1;
            y_d     = last ? '0 : (last_x ? py + 1'b1 : py);
        end
        s1_v_d     = pass;
        s1_start_d = pass && int'(px) == CROP_X0 && int'(py) == CROP_Y0;
        s1_pix_d   = mipi_st_data;
`ifdef MIPI_RGB555_DITHER_EN
        s1_x0_d    = px[0];
        s1_y0_d    = py[0];
`endif
    end

    // Stage 2: colour conversion of the stage-1 pixel; idle cycles drive zero data
    always_comb begin
`ifdef MIPI_RGB555_DITHER_EN
        thr = s1_y0_q ? (s1_x0_q ? 8'd2 : 8'd6) : (s1_x0_q ? 8'd4 : 8'd0);
        rgb = {dith5(s1_pix_q[23:16], thr), dith5(s1_pix_q[15:8], thr), dith5(s1_pix_q[7:0], thr)};
`else
        rgb = {s1_pix_q[23:19], s1_pix_q[15:11], s1_pix_q[7:3]};
`endif
        out_data_d  = s1_v_q ? rgb : '0;
        out_dv_d    = s1_v_q;
        out_start_d = s1_start_q;
    end

    // All state; reset discards in-flight pixels
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            s1_v_q      <= 1'b0;
            s1_start_q  <= 1'b0;
            s1_pix_q    <= '0;
            out_dv_q    <= 1'b0;
            out_start_q <= 1'b0;
            out_data_q  <= '0;
`ifdef MIPI_RGB555_DITHER_EN
            s1_x0_q     <= 1'b0;
            s1_y0_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            s1_v_q      <= s1_v_d;
            s1_start_q  <= s1_start_d;
            s1_pix_q    <= s1_pix_d;
            out_dv_q    <= out_dv_d;
            out_start_q <= out_start_d;
            out_data_q  <= out_data_d;
`ifdef MIPI_RGB555_DITHER_EN
            s1_x0_q     <= s1_x0_d;
            s1_y0_q     <= s1_y0_d;
`endif
        end
    end

    assign arb_mipi_data  = out_data_q;
    assign arb_mipi_dv    = out_dv_q;
    assign arb_mipi_start = out_start_q;
    assign frame_cnt      = cnt_q;
    assign frame_err      = err_q;
    assign in_frame       = state_q == ACTIVE;
endmodule

// File: tb/tb_mipi_rgb555_packer.sv
// tb_mipi_rgb555_packer: scoreboard bench for a full-frame and a cropped packer on one 8x4 input stream
module tb_mipi_rgb555_packer;
    logic        clk = 1'b0, rst = 1'b1;
    logic [23:0] din = '0;
    logic        st = 1'b0, dv = 1'b0;
    logic [14:0] a_data, b_data;
    logic        a_dv, a_start, a_err, a_inf, b_dv, b_start, b_err, b_inf;
    logic [15:0] a_cnt, b_cnt;

    typedef struct {
        logic [14:0] d;
        logic        s;
        int          due;
    } exp_t;

    exp_t        qa[$], qb[$];
    int          checks = 0, errors = 0, cyc = 0;
    logic        m_active = 1'b0;
    int          mx = 0, my = 0;
    logic [15:0] m_cnt = '0;

    mipi_rgb555_packer #(.IMG_W(8), .IMG_H(4), .CROP_X0(0), .CROP_Y0(0), .OUT_W(8), .OUT_H(4)) dut_a (
        .clk_clk(clk), .reset_reset(rst), .mipi_st_data(din), .mipi_st_start(st), .mipi_st_dv(dv),
        .arb_mipi_data(a_data), .arb_mipi_dv(a_dv), .arb_mipi_start(a_start),
        .frame_cnt(a_cnt), .frame_err(a_err), .in_frame(a_inf));

    mipi_rgb555_packer #(.IMG_W(8), .IMG_H(4), .CROP_X0(2), .CROP_Y0(1), .OUT_W(4), .OUT_H(2)) dut_b (
        .clk_clk(clk), .reset_reset(rst), .mipi_st_data(din), .mipi_st_start(st), .mipi_st_dv(dv),
        .arb_mipi_data(b_data), .arb_mipi_dv(b_dv), .arb_mipi_start(b_start),
        .frame_cnt(b_cnt), .frame_err(b_err), .in_frame(b_inf));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [14:0] conv(input logic [23:0] p, input int x, input int y);
        int tt[4] = '{0, 4, 6, 2};
        int t, c;
        logic [14:0] r;
        t = 0;
`ifdef MIPI_RGB555_DITHER_EN
        t = tt[(y % 2) * 2 + (x % 2)];
`endif
        for (int i = 0; i < 3; i++) begin
            c = int'(p[23 - 8 * i -: 8]) + t;
            if (c > 255) c = 255;
            r[14 - 5 * i -: 5] = 5'(c >> 3);
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic mon(input int id, input logic v, input logic s, input logic [14:0] d);
        exp_t e;
        int   n;
        n = (id == 0) ? qa.size() : qb.size();
        if (v) begin
            chk(id == 0 ? "a_dv_expected" : "b_dv_expected", 32'(n > 0), 32'(1));
            if (n > 0) begin
                if (id == 0) e = qa.pop_front();
                else e = qb.pop_front();
                chk(id == 0 ? "a_data" : "b_data", 32'(d), 32'(e.d));
                chk(id == 0 ? "a_start" : "b_start", 32'(s), 32'(e.s));
                chk(id == 0 ? "a_latency" : "b_latency", 32'(cyc), 32'(e.due));
            end
        end else if (n > 0) begin
            e = (id == 0) ? qa[0] : qb[0];
            if (e.due <= cyc) chk(id == 0 ? "a_missing_dv" : "b_missing_dv", 32'(v), 32'(1));
        end
    endtask

    always @(negedge clk) if (!rst) begin
        mon(0, a_dv, a_start, a_data);
        mon(1, b_dv, b_start, b_data);
    end

    task automatic step(input logic v, input logic s, input logic [23:0] d);
        logic err, acc;
        int   px, py;
        exp_t e;
        dv  = v;
        st  = s;
        din = d;
        err = v && s && m_active;
        acc = v && (s || m_active);
        if (acc) begin
            px  = s ? 0 : mx;
            py  = s ? 0 : my;
            e.d = conv(d, px, py);
            e.due = cyc + 2;
            e.s = px == 0 && py == 0;
            qa.push_back(e);
            if (px >= 2 && px < 6 && py >= 1 && py < 3) begin
                e.s = px == 2 && py == 1;
                qb.push_back(e);
            end
            m_active = 1'b1;
            if (px == 7 && py == 3) begin
                m_active = 1'b0;
                m_cnt++;
                mx = 0;
                my = 0;
            end else if (px == 7) begin
                mx = 0;
                my = py + 1;
            end else begin
                mx = px + 1;
                my = py;
            end
        end
        @(posedge clk);
        #1;
        chk("a_frame_err", 32'(a_err), 32'(err));
        chk("b_frame_err", 32'(b_err), 32'(err));
        chk("a_in_frame", 32'(a_inf), 32'(m_active));
        chk("b_in_frame", 32'(b_inf), 32'(m_active));
        chk("a_frame_cnt", 32'(a_cnt), 32'(m_cnt));
        chk("b_frame_cnt", 32'(b_cnt), 32'(m_cnt));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        dv  = 1'b0;
        st  = 1'b0;
        qa.delete();
        qb.delete();
        m_active = 1'b0;
        mx = 0;
        my = 0;
        m_cnt = '0;
        #1;
        chk("rst_a_data", 32'(a_data), 32'(0));
        chk("rst_a_dv", 32'(a_dv), 32'(0));
        chk("rst_a_start", 32'(a_start), 32'(0));
        chk("rst_a_cnt", 32'(a_cnt), 32'(0));
        chk("rst_a_err", 32'(a_err), 32'(0));
        chk("rst_a_in_frame", 32'(a_inf), 32'(0));
        chk("rst_b_dv", 32'(b_dv), 32'(0));
        chk("rst_b_cnt", 32'(b_cnt), 32'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        // start without dv is ignored
        step(1'b0, 1'b1, 24'hFF8040);
        // test 1: uniform full frame
        for (int i = 0; i < 32; i++) step(1'b1, i == 0, 24'hFF8040);
        repeat (3) step(1'b0, 1'b0, 24'h0);
        // test 2: ramp frame, cropped window on dut_b
        for (int i = 0; i < 32; i++) step(1'b1, i == 0, 24'(i * 24'h070503 + 24'h102030));
        repeat (3) step(1'b0, 1'b0, 24'h0);
        // test 3: test 1 with random gaps
        for (int i = 0; i < 32; i++) begin
            while ($urandom_range(1, 0) == 1) step(1'b0, 1'b0, 24'h0);
            step(1'b1, i == 0, 24'hFF8040);
        end
        repeat (3) step(1'b0, 1'b0, 24'h0);
        // test 4: restart mid-frame after 10 beats, then a complete frame
        for (int i = 0; i < 10; i++) step(1'b1, i == 0, 24'(i * 24'h010203));
        for (int i = 0; i < 32; i++) step(1'b1, i == 0, 24'(i * 24'h0A0B0C + 24'h00FF00));
        repeat (3) step(1'b0, 1'b0, 24'h0);
        // test 5: reset after 12 beats, then beats without start are dropped
        for (int i = 0; i < 12; i++) step(1'b1, i == 0, 24'h123456);
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 24'hABCDEF);
        repeat (3) step(1'b0, 1'b0, 24'h0);
        // test 6: dither threshold and saturation points
        for (int i = 0; i < 32; i++)
            step(1'b1, i == 0, i == 1 ? 24'h050505 : i == 8 ? 24'hFFFFFF : i == 9 ? 24'hFBFCFD : 24'(i * 24'h030303));
        repeat (4) step(1'b0, 1'b0, 24'h0);
        chk("qa_drained", 32'(qa.size()), 32'(0));
        chk("qb_drained", 32'(qb.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
